// File: rtl/user_pcie_stream_rd_engine.sv
// user_pcie_stream_rd_engine
// Multi-channel system-to-user DMA read engine. Each channel walks its host
// buffer in read requests that never cross a MAX_RD_BYTES boundary. Channels
// share one request port through a round-robin arbiter. Completion beats are
// steered to the per-channel user FIFOs by tag.
module user_pcie_stream_rd_engine #(
  parameter int         NUM_CH       = 4,
  parameter int         DATA_W       = 64,
  parameter int         MAX_RD_BYTES = 4096,
  parameter logic [7:0] TAG_BASE     = 8'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      ch_en_i,
  input  logic [32*NUM_CH-1:0]   ch_src_addr_i,
  input  logic [32*NUM_CH-1:0]   ch_len_i,
  input  logic [16*NUM_CH-1:0]   ch_fifo_space_i,
  output logic [NUM_CH-1:0]      ch_done_o,
  input  logic [NUM_CH-1:0]      ch_done_ack_i,
  output logic                   dma_rd_req_o,
  input  logic                   dma_req_ack_i,
  output logic [31:0]            dma_rd_req_addr_o,
  output logic [11:0]            dma_rd_req_len_o,
  output logic [7:0]             dma_tag_o,
  input  logic [7:0]             dma_tag_i,
  input  logic                   dma_data_valid_i,
  input  logic [DATA_W-1:0]      dma_data_i,
  output logic [NUM_CH-1:0]      ch_wr_en_o,
  output logic [DATA_W-1:0]      ch_wr_data_o,
  output logic                   stray_cpl_o
);

  localparam int          W_BYTES  = DATA_W / 8;
  localparam int          W_SH     = $clog2(W_BYTES);
  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] LEN_MASK = ~(32'(W_BYTES) - 32'd1);
  localparam logic [11:0] OFF_MASK = 12'(MAX_RD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } st_t;

  st_t             st_q     [NUM_CH];
  logic [31:0]     addr_q   [NUM_CH];
  logic [31:0]     rem_q    [NUM_CH];
  logic [12:0]     chunk_q  [NUM_CH];
  logic [9:0]      outst_q  [NUM_CH];
  logic [NUM_CH-1:0] acked_q;
  logic [CH_W-1:0] rr_ptr_q;
  logic [CH_W-1:0] req_ch_q;

  logic [12:0]     bound_c  [NUM_CH];
  logic [12:0]     chunk_c  [NUM_CH];
  logic [9:0]      words_c  [NUM_CH];
  logic [NUM_CH-1:0] elig;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_ch;
  logic [CH_W:0]   scan_idx;

  logic [7:0]      tag_off;
  logic            tag_in_rng;
  logic [CH_W-1:0] cpl_ch;
  logic            cpl_hit;
  logic            cpl_stray;

  logic [NUM_CH-1:0] wr_en_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              stray_p1;

  // Chunk size to the next MAX_RD_BYTES boundary and per-channel eligibility.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      bound_c[c] = 13'(MAX_RD_BYTES) - {1'b0, addr_q[c][11:0] & OFF_MASK};
      chunk_c[c] = (rem_q[c] < {19'd0, bound_c[c]}) ? rem_q[c][12:0] : bound_c[c];
      words_c[c] = 10'(chunk_c[c] >> W_SH);
      elig[c]    = (st_q[c] == ST_REQ) && ch_en_i[c] &&
                   (16'(words_c[c]) <= ch_fifo_space_i[16*c +: 16]);
    end
  end

  // Round-robin pick of the first eligible channel at or after rr_ptr.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_ch   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (scan_idx >= (CH_W+1)'(NUM_CH)) begin
        scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      end
      if (!gnt_vld && elig[scan_idx[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = scan_idx[CH_W-1:0];
      end
    end
    if (dma_rd_req_o) begin
      gnt_vld = 1'b0;
    end
  end

  // Completion tag decode: forward, silently ignore, or flag as stray.
  always_comb begin
    tag_off    = dma_tag_i - TAG_BASE;
    tag_in_rng = dma_data_valid_i && (tag_off < 8'(NUM_CH));
    cpl_ch     = tag_off[CH_W-1:0];
    cpl_hit    = tag_in_rng && (st_q[cpl_ch] == ST_WAIT) && (outst_q[cpl_ch] != 10'd0);
    cpl_stray  = tag_in_rng && !cpl_hit;
  end

  // Done flag decodes straight from the channel state register.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_done_o[c] = (st_q[c] == ST_DONE);
    end
  end

  // Channel FSMs, request registers and the completion pipeline stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dma_rd_req_o      <= 1'b0;
      dma_rd_req_addr_o <= '0;
      dma_rd_req_len_o  <= '0;
      dma_tag_o         <= '0;
      rr_ptr_q          <= '0;
      req_ch_q          <= '0;
      acked_q           <= '0;
      wr_en_p1          <= '0;
      wr_data_p1        <= '0;
      stray_p1          <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]    <= ST_IDLE;
        addr_q[c]  <= '0;
        rem_q[c]   <= '0;
        chunk_q[c] <= '0;
        outst_q[c] <= '0;
      end
    end else begin
      // stage p1: registered completion beat towards the user FIFOs
      for (int c = 0; c < NUM_CH; c++) begin
        wr_en_p1[c] <= cpl_hit && (cpl_ch == CH_W'(c));
      end
      wr_data_p1 <= dma_data_i;
      stray_p1   <= cpl_stray;

      if (dma_rd_req_o && dma_req_ack_i) begin
        dma_rd_req_o      <= 1'b0;
        acked_q[req_ch_q] <= 1'b1;
      end

      if (gnt_vld) begin
        dma_rd_req_o      <= 1'b1;
        dma_rd_req_addr_o <= addr_q[gnt_ch];
        dma_rd_req_len_o  <= chunk_c[gnt_ch][11:0];
        dma_tag_o         <= TAG_BASE + 8'(gnt_ch);
        req_ch_q          <= gnt_ch;
        rr_ptr_q          <= (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + CH_W'(1);
      end

      for (int c = 0; c < NUM_CH; c++) begin
        case (st_q[c])
          ST_IDLE: begin
            if (ch_en_i[c]) begin
              addr_q[c] <= ch_src_addr_i[32*c +: 32];
              rem_q[c]  <= ch_len_i[32*c +: 32] & LEN_MASK;
              st_q[c]   <= ((ch_len_i[32*c +: 32] & LEN_MASK) == 32'd0) ? ST_DONE : ST_REQ;
            end
          end
          ST_REQ: begin
            if (!ch_en_i[c]) begin
              st_q[c] <= ST_IDLE;
            end else if (gnt_vld && (gnt_ch == CH_W'(c))) begin
              st_q[c]    <= ST_WAIT;
              outst_q[c] <= words_c[c];
              chunk_q[c] <= chunk_c[c];
              acked_q[c] <= 1'b0;
            end
          end
          ST_WAIT: begin
            if ((outst_q[c] == 10'd0) && acked_q[c]) begin
              addr_q[c] <= addr_q[c] + 32'(chunk_q[c]);
              rem_q[c]  <= rem_q[c] - 32'(chunk_q[c]);
              if (!ch_en_i[c]) begin
                st_q[c] <= ST_IDLE;
              end else if (rem_q[c] == 32'(chunk_q[c])) begin
                st_q[c] <= ST_DONE;
              end else begin
                st_q[c] <= ST_REQ;
              end
            end else if (cpl_hit && (cpl_ch == CH_W'(c))) begin
              outst_q[c] <= outst_q[c] - 10'd1;
            end
          end
          ST_DONE: begin
            if (ch_done_ack_i[c] && !ch_en_i[c]) begin
              st_q[c] <= ST_IDLE;
            end
          end
          default: st_q[c] <= ST_IDLE;
        endcase
      end
    end
  end

  assign ch_wr_en_o   = wr_en_p1;
  assign ch_wr_data_o = wr_data_p1;
  assign stray_cpl_o  = stray_p1;

endmodule

// File: tb/tb_user_pcie_stream_rd_engine.sv
// Scoreboard bench for user_pcie_stream_rd_engine: a host model acks requests
// and returns completions, pushing expected FIFO data as it sends; a monitor
// pops and compares whenever the DUT presents a request, write or stray pulse.
module tb_user_pcie_stream_rd_engine;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NUM_CH-1:0]    ch_en_i;
  logic [32*NUM_CH-1:0] ch_src_addr_i;
  logic [32*NUM_CH-1:0] ch_len_i;
  logic [16*NUM_CH-1:0] ch_fifo_space_i;
  logic [NUM_CH-1:0]    ch_done_o;
  logic [NUM_CH-1:0]    ch_done_ack_i;
  logic                 dma_rd_req_o;
  logic                 dma_req_ack_i;
  logic [31:0]          dma_rd_req_addr_o;
  logic [11:0]          dma_rd_req_len_o;
  logic [7:0]           dma_tag_o;
  logic [7:0]           dma_tag_i;
  logic                 dma_data_valid_i;
  logic [DATA_W-1:0]    dma_data_i;
  logic [NUM_CH-1:0]    ch_wr_en_o;
  logic [DATA_W-1:0]    ch_wr_data_o;
  logic                 stray_cpl_o;

  always #5 clk = ~clk;

  user_pcie_stream_rd_engine #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_RD_BYTES(4096), .TAG_BASE(8'd0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .ch_en_i(ch_en_i), .ch_src_addr_i(ch_src_addr_i),
    .ch_len_i(ch_len_i), .ch_fifo_space_i(ch_fifo_space_i), .ch_done_o(ch_done_o),
    .ch_done_ack_i(ch_done_ack_i), .dma_rd_req_o(dma_rd_req_o), .dma_req_ack_i(dma_req_ack_i),
    .dma_rd_req_addr_o(dma_rd_req_addr_o), .dma_rd_req_len_o(dma_rd_req_len_o),
    .dma_tag_o(dma_tag_o), .dma_tag_i(dma_tag_i), .dma_data_valid_i(dma_data_valid_i),
    .dma_data_i(dma_data_i), .ch_wr_en_o(ch_wr_en_o), .ch_wr_data_o(ch_wr_data_o),
    .stray_cpl_o(stray_cpl_o)
  );

  typedef struct packed { logic [31:0] addr; logic [11:0] len; } req_t;
  typedef struct packed { logic [7:0] tag; logic exp_stray; } sbeat_t;

  int checks = 0;
  int errors = 0;

  req_t        exp_req [NUM_CH][$];
  logic [63:0] exp_wr  [NUM_CH][$];
  logic        exp_stray_q[$];
  sbeat_t      stray_beats[$];
  int          grant_log[$];

  int  pend [NUM_CH];
  bit  ack_en  = 1'b1;
  bit  beat_en = 1'b1;

  int cyc = 0;
  int wr_total    [NUM_CH];
  int wr_since    [NUM_CH];
  int last_wr_cyc [NUM_CH];
  int stray_seen = 0;
  logic [NUM_CH-1:0] prev_done = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Host model: acks requests, then returns their beats interleaved per tag.
  initial begin
    int          host_rr;
    int          seq;
    bit          sent;
    int          idx;
    logic [11:0] cap_len;
    logic [7:0]  cap_tag;
    sbeat_t      b;
    host_rr = 0; seq = 0; cap_len = '0; cap_tag = '0;
    for (int c = 0; c < NUM_CH; c++) pend[c] = 0;
    dma_req_ack_i = 1'b0; dma_data_valid_i = 1'b0; dma_tag_i = '0; dma_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (dma_req_ack_i && (cap_tag < 8'(NUM_CH)))
        pend[int'(cap_tag)] += (cap_len == 12'd0) ? 512 : int'(cap_len) / 8;
      dma_req_ack_i = ack_en && dma_rd_req_o;
      if (dma_req_ack_i) begin
        cap_len = dma_rd_req_len_o;
        cap_tag = dma_tag_o;
      end
      dma_data_valid_i = 1'b0;
      if (stray_beats.size() != 0) begin
        b = stray_beats.pop_front();
        seq++;
        dma_data_valid_i = 1'b1;
        dma_tag_i  = b.tag;
        dma_data_i = {b.tag, 24'(seq), $urandom()};
        if (b.exp_stray) exp_stray_q.push_back(1'b1);
      end else if (beat_en) begin
        sent = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          idx = (host_rr + i) % NUM_CH;
          if (!sent && pend[idx] > 0) begin
            sent = 1'b1;
            seq++;
            dma_data_valid_i = 1'b1;
            dma_tag_i  = 8'(idx);
            dma_data_i = {8'(idx), 24'(seq), $urandom()};
            exp_wr[idx].push_back(dma_data_i);
            pend[idx]--;
            host_rr = (idx + 1) % NUM_CH;
          end
        end
      end
    end
  end

  // Monitor: compares every DUT request, FIFO write, stray pulse and done rise.
  always @(negedge clk) begin
    req_t e;
    int   t;
    if (|ch_wr_en_o) begin
      chk("wr_onehot", 64'($onehot(ch_wr_en_o)), 64'd1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_wr_en_o[c]) begin
          chk($sformatf("wr_expected_ch%0d", c), 64'(exp_wr[c].size() != 0), 64'd1);
          if (exp_wr[c].size() != 0)
            chk($sformatf("wr_data_ch%0d", c), ch_wr_data_o, exp_wr[c].pop_front());
          wr_total[c]++;
          wr_since[c]++;
          last_wr_cyc[c] = cyc;
        end
      end
    end
    if (stray_cpl_o) begin
      chk("stray_expected", 64'(exp_stray_q.size() != 0), 64'd1);
      if (exp_stray_q.size() != 0) void'(exp_stray_q.pop_front());
      stray_seen++;
    end
    if (dma_rd_req_o && dma_req_ack_i) begin
      t = int'(dma_tag_o);
      chk("req_tag_range", 64'(t < NUM_CH), 64'd1);
      if (t < NUM_CH) begin
        grant_log.push_back(t);
        chk($sformatf("req_expected_ch%0d", t), 64'(exp_req[t].size() != 0), 64'd1);
        if (exp_req[t].size() != 0) begin
          e = exp_req[t].pop_front();
          chk($sformatf("req_addr_ch%0d", t), 64'(dma_rd_req_addr_o), 64'(e.addr));
          chk($sformatf("req_len_ch%0d", t), 64'(dma_rd_req_len_o), 64'(e.len));
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_done_o[c] && !prev_done[c]) begin
        if (wr_since[c] > 0)
          chk($sformatf("done_latency_ch%0d", c), 64'(cyc), 64'(last_wr_cyc[c] + 1));
        wr_since[c] = 0;
      end
    end
    prev_done = ch_done_o;
  end

  function automatic bit sb_idle();
    bit r;
    r = !dma_rd_req_o && (stray_beats.size() == 0) && (exp_stray_q.size() == 0);
    for (int c = 0; c < NUM_CH; c++)
      r = r && (pend[c] == 0) && (exp_wr[c].size() == 0) && (exp_req[c].size() == 0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !sb_idle()) begin
      step();
      n++;
    end
    chk(name, 64'(n < max_cyc), 64'd1);
    repeat (4) step();
  endtask

  task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] l, input logic [15:0] s);
    ch_src_addr_i[32*c +: 32]  = a;
    ch_len_i[32*c +: 32]       = l;
    ch_fifo_space_i[16*c +: 16] = s;
  endtask

  task automatic ack_done(input string name, input logic [NUM_CH-1:0] m);
    ch_en_i       = ch_en_i & ~m;
    ch_done_ack_i = m;
    step();
    chk(name, 64'(ch_done_o & m), 64'd0);
    ch_done_ack_i = '0;
  endtask

  initial begin
    int w0;
    int w1;
    int n;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_total[c] = 0; wr_since[c] = 0; last_wr_cyc[c] = 0;
    end
    rst_i = 1'b1; ch_en_i = '0; ch_done_ack_i = '0;
    ch_src_addr_i = '0; ch_len_i = '0; ch_fifo_space_i = '0;
    repeat (3) step();
    chk("rst_req", 64'(dma_rd_req_o), 64'd0);
    chk("rst_done", 64'(ch_done_o), 64'd0);
    chk("rst_wr_en", 64'(ch_wr_en_o), 64'd0);
    chk("rst_stray", 64'(stray_cpl_o), 64'd0);
    chk("rst_req_addr", 64'(dma_rd_req_addr_o), 64'd0);
    rst_i = 1'b0;
    step();

    // Four channels: round-robin grant order and per-channel steering.
    exp_req[0].push_back('{32'h0000_0FC0, 12'd64});
    exp_req[0].push_back('{32'h0000_1000, 12'd192});
    for (int c = 1; c < NUM_CH; c++) begin
      exp_req[c].push_back('{32'(c << 16) + 32'h0F80, 12'd128});
      exp_req[c].push_back('{32'(c << 16) + 32'h1000, 12'd128});
    end
    set_ch(0, 32'h0000_0FC0, 32'd256, 16'hFFFF);
    for (int c = 1; c < NUM_CH; c++) set_ch(c, 32'(c << 16) + 32'h0F80, 32'd256, 16'hFFFF);
    grant_log.delete();
    ch_en_i = 4'hF;
    drain("t3_drain", 2000);
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("t3_words_ch%0d", c), 64'(wr_total[c]), 64'd32);
    chk("t3_grant_cnt", 64'(grant_log.size()), 64'd8);
    if (grant_log.size() >= 5) begin
      chk("t3_grant0", 64'(grant_log[0]), 64'd0);
      chk("t3_grant1", 64'(grant_log[1]), 64'd1);
      chk("t3_grant2", 64'(grant_log[2]), 64'd2);
      chk("t3_grant3", 64'(grant_log[3]), 64'd3);
      chk("t3_grant4", 64'(grant_log[4]), 64'd0);
    end
    chk("t3_done", 64'(ch_done_o), 64'hF);
    ack_done("t3_done_clr", 4'hF);

    // Single channel 10000 bytes: two full 4 KB requests then 1808 bytes.
    exp_req[0].push_back('{32'h0000_1000, 12'd0});
    exp_req[0].push_back('{32'h0000_2000, 12'd0});
    exp_req[0].push_back('{32'h0000_3000, 12'd1808});
    w0 = wr_total[0];
    set_ch(0, 32'h0000_1000, 32'd10000, 16'hFFFF);
    ch_en_i[0] = 1'b1;
    drain("t1_drain", 6000);
    chk("t1_words", 64'(wr_total[0] - w0), 64'd1250);
    chk("t1_done", 64'(ch_done_o[0]), 64'd1);
    ack_done("t1_done_clr", 4'h1);

    // Misaligned start: first request stops at the 4 KB boundary.
    exp_req[0].push_back('{32'h0000_0F80, 12'd128});
    exp_req[0].push_back('{32'h0000_1000, 12'd384});
    w0 = wr_total[0];
    set_ch(0, 32'h0000_0F80, 32'd512, 16'hFFFF);
    ch_en_i[0] = 1'b1;
    drain("t2_drain", 1000);
    chk("t2_words", 64'(wr_total[0] - w0), 64'd64);
    chk("t2_done", 64'(ch_done_o[0]), 64'd1);
    ack_done("t2_done_clr", 4'h1);

    // Backpressure: ch0 needs 512 words but sees 100 free.
    exp_req[1].push_back('{32'h0000_2000, 12'd512});
    w0 = wr_total[0]; w1 = wr_total[1];
    set_ch(0, 32'h0000_0000, 32'd4096, 16'd100);
    set_ch(1, 32'h0000_2000, 32'd512, 16'hFFFF);
    ch_en_i[1:0] = 2'b11;
    drain("t4_drain", 1000);
    chk("t4_ch1_words", 64'(wr_total[1] - w1), 64'd64);
    chk("t4_ch0_words", 64'(wr_total[0] - w0), 64'd0);
    chk("t4_no_req", 64'(dma_rd_req_o), 64'd0);
    ack_done("t4_ch1_done_clr", 4'h2);
    exp_req[0].push_back('{32'h0000_0000, 12'd0});
    ch_fifo_space_i[15:0] = 16'd512;
    n = 0;
    while (n < 4 && !dma_rd_req_o) begin
      step();
      n++;
    end
    chk("t4_grant_latency_ok", 64'(n <= 2), 64'd1);
    drain("t4_drain2", 1500);
    chk("t4_ch0_words", 64'(wr_total[0] - w0), 64'd512);
    ack_done("t4_ch0_done_clr", 4'h1);

    // Stray beats: in-range tag to an idle channel, and an out-of-range tag.
    w0 = wr_total[2]; n = stray_seen;
    stray_beats.push_back('{8'd2, 1'b1});
    stray_beats.push_back('{8'h40, 1'b0});
    drain("t5_drain", 100);
    chk("t5_stray_cnt", 64'(stray_seen - n), 64'd1);
    chk("t5_no_write", 64'(wr_total[2] - w0), 64'd0);

    // Disable during WAIT_CPL: beats still land, no done is raised.
    beat_en = 1'b0;
    exp_req[2].push_back('{32'h0000_8000, 12'd1024});
    set_ch(2, 32'h0000_8000, 32'd1024, 16'hFFFF);
    ch_en_i[2] = 1'b1;
    n = 0;
    while (n < 50 && pend[2] == 0) begin
      step();
      n++;
    end
    chk("t5_req_accepted", 64'(pend[2]), 64'd128);
    ch_en_i[2] = 1'b0;
    repeat (3) step();
    beat_en = 1'b1;
    drain("t5_drain2", 1000);
    chk("t5_abort_words", 64'(wr_total[2] - w0), 64'd128);
    chk("t5_abort_no_done", 64'(ch_done_o[2]), 64'd0);
    n = stray_seen;
    stray_beats.push_back('{8'd2, 1'b1});
    drain("t5_drain3", 100);
    chk("t5_idle_stray", 64'(stray_seen - n), 64'd1);

    // Length below one word rounds to zero: done next cycle, no request.
    set_ch(3, 32'h0000_4000, 32'd4, 16'hFFFF);
    chk("t6_pre_done", 64'(ch_done_o[3]), 64'd0);
    ch_en_i[3] = 1'b1;
    step();
    chk("t6_done", 64'(ch_done_o[3]), 64'd1);
    chk("t6_no_req", 64'(dma_rd_req_o), 64'd0);
    ack_done("t6_done_clr", 4'h8);

    // Reset with a request pending; a late completion is then stray.
    ack_en = 1'b0;
    set_ch(1, 32'h0000_0100, 32'd64, 16'hFFFF);
    ch_en_i[1] = 1'b1;
    n = 0;
    while (n < 20 && !dma_rd_req_o) begin
      step();
      n++;
    end
    chk("t7_req_seen", 64'(dma_rd_req_o), 64'd1);
    chk("t7_req_tag", 64'(dma_tag_o), 64'd1);
    chk("t7_req_addr", 64'(dma_rd_req_addr_o), 64'h100);
    chk("t7_req_len", 64'(dma_rd_req_len_o), 64'd64);
    rst_i = 1'b1;
    ch_en_i = '0;
    step();
    chk("t7_req_cleared", 64'(dma_rd_req_o), 64'd0);
    chk("t7_done_cleared", 64'(ch_done_o), 64'd0);
    rst_i = 1'b0;
    ack_en = 1'b1;
    n = stray_seen;
    stray_beats.push_back('{8'd1, 1'b1});
    drain("t7_drain", 100);
    chk("t7_late_stray", 64'(stray_seen - n), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/user_pcie_stream_rd_engine.md
# user_pcie_stream_rd_engine

Parametrised multi-channel system-to-user DMA read engine. Splits each channel's host buffer into PCIe memory-read requests that never cross a MAX_RD_BYTES boundary. Arbitrates the channels round-robin onto the single TX-engine request port and steers RX completion data to per-channel user stream FIFOs by tag. It sits between the register set, the PCIe arbitrator/TX engine, the RX engine and the user-logic write FIFOs; those FIFOs are external.

## Interface
- NUM_CH, 4 — number of channels, 1..8.
- DATA_W, 64 — completion/stream data width, 64 or 128.
- MAX_RD_BYTES, 4096 — maximum read request size; power of 2, 128..4096.
- TAG_BASE, 8'd0 — channel c uses tag TAG_BASE+c.

Ports:
- clk_i  in  1  — single clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  — synchronous, active-high reset.
- ch_en_i  in  NUM_CH  — per-channel transfer enable.
- ch_src_addr_i  in  32*NUM_CH  — host source byte address; channel c is in bits [32c+31:32c].
- ch_len_i  in  32*NUM_CH  — transfer length in bytes. Low log2(DATA_W/8) bits are ignored.
- ch_fifo_space_i  in  16*NUM_CH  — free words in channel c's user FIFO.
- ch_done_o  out  NUM_CH  — transfer complete; held until acknowledged.
- ch_done_ack_i  in  NUM_CH  — done acknowledge from the register set.
- dma_rd_req_o  out  1  — read request to the arbitrator.
- dma_req_ack_i  in  1  — arbitrator accept.
- dma_rd_req_addr_o  out  32  — request byte address.
- dma_rd_req_len_o  out  12  — request bytes; 0 encodes 4096.
- dma_tag_o  out  8  — request tag.
- dma_tag_i  in  8  — RX completion tag.
- dma_data_valid_i  in  1  — RX completion beat valid.
- dma_data_i  in  DATA_W  — RX completion data.
- ch_wr_en_o  out  NUM_CH  — one-hot write strobe to channel FIFO.
- ch_wr_data_o  out  DATA_W  — shared FIFO write data.
- stray_cpl_o  out  1  — one-cycle pulse on an unexpected completion beat.

## Operation
- W = DATA_W/8 bytes per word. Each channel has a 32-bit address, a 32-bit remaining byte count and a 10-bit outstanding-word counter.
- Per-channel FSM: IDLE, REQ, WAIT_CPL, DONE.
- IDLE:
  - ch_done_o=0.
  - On ch_en_i=1: latch address and length (rounded down to a multiple of W).
  - Length 0 -> DONE; otherwise -> REQ.
- REQ:
  - chunk = min(remaining, MAX_RD_BYTES − (addr mod MAX_RD_BYTES)).
  - The channel is eligible when chunk/W ≤ its fifo_space.
  - ch_en_i=0 in REQ -> IDLE; the transfer is aborted and no done is raised.
- Arbiter:
  - When no request is pending, grant the first eligible channel at or after rr_ptr, modulo NUM_CH.
  - On grant: load addr, len (chunk[11:0]) and TAG_BASE+c into the request registers; set dma_rd_req_o; set rr_ptr = c+1; move the channel to WAIT_CPL with outstanding = chunk/W.
  - Only one request is pending at a time. Several channels may sit in WAIT_CPL concurrently.
- Completions:
  - A beat with tag TAG_BASE+c (c<NUM_CH) for a channel in WAIT_CPL with outstanding>0 decrements outstanding and is forwarded to FIFO c.
  - Tags outside TAG_BASE..TAG_BASE+NUM_CH−1 are ignored silently.
  - A beat with an in-range tag for a channel not in WAIT_CPL, or with outstanding=0, is dropped and pulses stray_cpl_o.
- WAIT_CPL end: when outstanding=0 and the request has been acked:
  - addr += chunk, remaining −= chunk.
  - If ch_en_i=0 -> IDLE.
  - Else if remaining=0 -> DONE.
  - Else -> REQ.
  - ch_en_i dropping mid-WAIT_CPL does not abandon outstanding tags.
- DONE: ch_done_o=1. When ch_done_ack_i=1 and ch_en_i=0 -> IDLE.
- Reset:
  - All outputs 0; all channels IDLE; rr_ptr=0; counters 0.
  - Reset mid-transfer discards all state. Later completions for those tags are flagged stray.

## Timing
- Grant cycle g -> dma_rd_req_o=1 from g+1.
- dma_rd_req_o and its address/len/tag are held stable until dma_req_ack_i is sampled high. The request drops the next cycle.
- The next grant can be made the cycle after the ack.
- Completion beat at cycle k -> ch_wr_en_o/ch_wr_data_o at k+1; one pipeline register.
- ch_wr_en_o is at most one-hot, never for a dropped beat.
- Last beat of a chunk at k -> channel state updates at k+1. If it re-enters REQ, its earliest grant is k+2.
- A channel's done rises the cycle after its final beat is registered.
- A grant and a completion for the same channel in the same cycle cannot occur, since the channel is in REQ, not WAIT_CPL.
- Completions to other channels proceed during any arbitration cycle.
- Address arithmetic is 32-bit and wraps at 2^32 without error.

## Test plan
- Single channel, addr 0x1000, len 10000, DATA_W 64, MAX 4096: requests (0x1000, 0), (0x2000, 0), (0x3000, 1808), with the 0 length fields encoding 4096. Expect 1250 FIFO writes, ch_done_o after the last beat, and clear on ack with en=0.
- Misaligned start, addr 0x0F80, len 512, MAX 4096: requests (0x0F80, 128) then (0x1000, 384). No 4 KB crossing.
- Four channels all enabled, fifo_space 0xFFFF: grants occur in order 0,1,2,3,0…. Interleaved completions with tags 0..3 land only in the matching FIFOs. Per-channel word counts are exact.
- Backpressure: ch0 fifo_space 100 words with chunk 512 words. No ch0 request while ch1 is still granted. Raising space to 512 grants ch0 within 2 cycles.
- Stray/disable: a tag 2 beat while ch2 is IDLE gives a stray_cpl_o pulse and no write. Dropping ch_en_i mid-WAIT_CPL completes the outstanding beats, then returns to IDLE without done.
- Length 0 -> done the cycle after the enable is sampled, with no request. Assert rst_i with a request pending: dma_rd_req_o=0 on the next cycle.
